// File: rtl/memory_stage_if.sv
// memory_stage_if: shared instruction record type and the data-memory request/response bus
package memory_stage_pkg;
  localparam int ARCH_LEN = 32;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dst_reg;
    logic        is_l;
    logic        is_s;
    logic [2:0]  func3;
    logic [31:0] src_data_2;
    logic [31:0] dst_reg_data;
    logic        reg_data_ready;
  } inst_decoded_t;
endpackage

interface memory_stage_if #(
  parameter int ADDR_W = memory_stage_pkg::ARCH_LEN,
  parameter int DATA_W = memory_stage_pkg::ARCH_LEN
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: RV32 load/store stage on a variable-latency data port; MEM_MISALIGN_TRAP_EN enables the misaligned-access trap
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = ARCH_LEN,
  parameter int DATA_W = ARCH_LEN
) (
  input  logic           clk,
  input  logic           rst,
  input  inst_decoded_t  inst_mem_in,
  output logic           stall_out,
  output inst_decoded_t  inst_mem_out,
  memory_stage_if.master dmem,
  output logic           misalign_out
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t            state_q;
  inst_decoded_t     rec_q, out_q;
  logic              req_valid_q, we_q, misalign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [1:0]        lane_q;
  logic [1:0]        lane, lane_al;
  logic              is_byte, is_half, is_mem, mis;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wdata_d, load_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              ld_sgn;
  assign lane    = inst_mem_in.dst_reg_data[1:0];
  assign is_byte = inst_mem_in.func3[1:0] == 2'b00;
  assign is_half = inst_mem_in.func3[1:0] == 2'b01;
  assign is_mem  = inst_mem_in.valid && (inst_mem_in.is_l || inst_mem_in.is_s);
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_mem && ((is_half && lane[0]) || (!is_byte && !is_half && lane != 2'b00));
`else
  assign mis = 1'b0;
`endif
  assign lane_al = is_byte ? lane : is_half ? {lane[1], 1'b0} : 2'b00;
  assign be_d    = is_byte ? 4'b0001 << lane : is_half ? 4'b0011 << lane_al : 4'hF;
  assign wdata_d = is_byte ? {4{inst_mem_in.src_data_2[7:0]}} :
                   is_half ? {2{inst_mem_in.src_data_2[15:0]}} : inst_mem_in.src_data_2;
  assign ld_byte = dmem.resp_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = lane_q[1] ? dmem.resp_rdata[31:16] : dmem.resp_rdata[15:0];
  assign ld_sgn  = !rec_q.func3[2];
  assign load_d  = rec_q.func3[1:0] == 2'b00 ? {{24{ld_sgn && ld_byte[7]}}, ld_byte} :
                   rec_q.func3[1:0] == 2'b01 ? {{16{ld_sgn && ld_half[15]}}, ld_half} : dmem.resp_rdata;
  // Stall drops in the cycle whose edge registers the completion, so upstream advances on that same edge
  assign stall_out = (state_q == IDLE && is_mem && !mis) ||
                     (state_q == REQ && !(dmem.req_ready && we_q)) ||
                     (state_q == WAIT && !dmem.resp_valid);
  assign inst_mem_out   = out_q;
  assign misalign_out   = misalign_q;
  assign dmem.req_valid = req_valid_q;
  assign dmem.req_we    = we_q;
  assign dmem.req_addr  = addr_q;
  assign dmem.req_wdata = wdata_q;
  assign dmem.req_be    = be_q;
  // Access FSM: latch a memory op, hold the request until accepted, then wait for load data
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rec_q       <= '0;
      out_q       <= '0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      lane_q      <= '0;
      misalign_q  <= 1'b0;
    end else begin
      out_q      <= '0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mis) misalign_q <= 1'b1;
          else if (is_mem) begin
            rec_q       <= inst_mem_in;
            lane_q      <= lane_al;
            addr_q      <= {inst_mem_in.dst_reg_data[ADDR_W-1:2], 2'b00};
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= inst_mem_in.is_s;
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end else if (inst_mem_in.valid) out_q <= inst_mem_in;
        end
        REQ: begin
          if (dmem.req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= we_q ? IDLE : WAIT;
            if (we_q) begin
              out_q                <= rec_q;
              out_q.reg_data_ready <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (dmem.resp_valid) begin
            out_q                <= rec_q;
            out_q.dst_reg_data   <= load_d;
            out_q.reg_data_ready <= 1'b1;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed table-driven bench for memory_stage
module tb_memory_stage;
  import memory_stage_pkg::*;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall, mis;
  inst_decoded_t in_r, out_r;
  int            pass_n = 0;
  int            total_n = 0;

  memory_stage_if #(.ADDR_W(32), .DATA_W(32)) dm ();

  memory_stage dut (
    .clk          (clk),
    .rst          (rst),
    .inst_mem_in  (in_r),
    .stall_out    (stall),
    .inst_mem_out (out_r),
    .dmem         (dm.master),
    .misalign_out (mis)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
  } ld_vec_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [3:0]  rdy;
  } st_vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } alu_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic inst_decoded_t mk(input logic l, input logic s, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] d);
    inst_decoded_t r;
    r = '0;
    r.valid = 1'b1;
    r.pc = 32'h8000_0000 | a;
    r.dst_reg = 5'd7;
    r.is_l = l;
    r.is_s = s;
    r.func3 = f3;
    r.dst_reg_data = a;
    r.src_data_2 = d;
    return r;
  endfunction

  task automatic mem_op(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input int rdy_dly, input int rsp_dly, input logic spur,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data);
    int   st_cnt;
    logic held_bad;
    st_cnt = 0;
    held_bad = 1'b0;
    in_r = mk(!st, st, f3, addr, sdata);
    #1;
    if (stall) st_cnt++;
    tick();
    chk({name, ".req_valid"}, 32'(dm.req_valid), 32'd1);
    chk({name, ".req_addr"}, dm.req_addr, exp_addr);
    chk({name, ".req_we"}, 32'(dm.req_we), 32'(st));
    if (st) begin
      chk({name, ".be"}, 32'(dm.req_be), 32'(exp_be));
      chk({name, ".wdata"}, dm.req_wdata, exp_wdata);
    end
    for (int k = 0; k < rdy_dly; k++) begin
      dm.resp_valid = spur && k == 0;
      dm.resp_rdata = 32'hBAD0_BAD0;
      #1;
      if (stall) st_cnt++;
      tick();
      dm.resp_valid = 1'b0;
      if (dm.req_valid !== 1'b1 || dm.req_addr !== exp_addr || out_r.valid !== 1'b0 ||
          (st && (dm.req_be !== exp_be || dm.req_wdata !== exp_wdata))) held_bad = 1'b1;
    end
    chk({name, ".hold"}, 32'(held_bad), 32'd0);
    dm.req_ready = 1'b1;
    #1;
    if (stall) st_cnt++;
    tick();
    dm.req_ready = 1'b0;
    chk({name, ".req_drop"}, 32'(dm.req_valid), 32'd0);
    if (!st) begin
      for (int k = 0; k < rsp_dly; k++) begin
        #1;
        if (stall) st_cnt++;
        tick();
        if (out_r.valid !== 1'b0) held_bad = 1'b1;
      end
      dm.resp_valid = 1'b1;
      dm.resp_rdata = rdata;
      #1;
      if (stall) st_cnt++;
      tick();
      dm.resp_valid = 1'b0;
      chk({name, ".wait_quiet"}, 32'(held_bad), 32'd0);
    end
    in_r = '0;
    chk({name, ".valid"}, 32'(out_r.valid), 32'd1);
    chk({name, ".data"}, out_r.dst_reg_data, exp_data);
    chk({name, ".ready"}, 32'(out_r.reg_data_ready), 32'(!st));
    chk({name, ".pc"}, out_r.pc, 32'h8000_0000 | addr);
    chk({name, ".stall_cycles"}, st_cnt, st ? 1 + rdy_dly : 2 + rdy_dly + rsp_dly);
    tick();
    chk({name, ".pulse"}, 32'(out_r.valid), 32'd0);
  endtask

  alu_vec_t alu_tab[4];
  ld_vec_t  ld_tab[9];
  st_vec_t  st_tab[5];

  initial begin
    alu_tab[0] = '{32'h0000_0100, 32'h0000_1234};
    alu_tab[1] = '{32'h0000_0104, 32'hFFFF_0000};
    alu_tab[2] = '{32'h0000_0108, 32'h0000_0000};
    alu_tab[3] = '{32'h0000_010C, 32'h7FFF_FFFF};
    ld_tab[0] = '{3'b000, 32'h0000_0103, 32'h80FF_FF00, 32'hFFFF_FF80, 4'd0, 4'd0};
    ld_tab[1] = '{3'b000, 32'h0000_0100, 32'h1234_567F, 32'h0000_007F, 4'd1, 4'd0};
    ld_tab[2] = '{3'b100, 32'h0000_0101, 32'h0000_A500, 32'h0000_00A5, 4'd0, 4'd2};
    ld_tab[3] = '{3'b001, 32'h0000_0202, 32'h8001_0000, 32'hFFFF_8001, 4'd2, 4'd1};
    ld_tab[4] = '{3'b001, 32'h0000_0200, 32'h0000_7FFF, 32'h0000_7FFF, 4'd0, 4'd0};
    ld_tab[5] = '{3'b101, 32'h0000_0012, 32'hBEEF_0000, 32'h0000_BEEF, 4'd1, 4'd1};
    ld_tab[6] = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd0, 4'd0};
    ld_tab[7] = '{3'b011, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'd0, 4'd1};
    ld_tab[8] = '{3'b100, 32'h0000_0103, 32'h8000_0000, 32'h0000_0080, 4'd0, 4'd0};
    st_tab[0] = '{3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0000_0100, 4'b0010, 32'hABAB_ABAB, 4'd0};
    st_tab[1] = '{3'b000, 32'h0000_0103, 32'h1234_5678, 32'h0000_0100, 4'b1000, 32'h7878_7878, 4'd1};
    st_tab[2] = '{3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 4'd3};
    st_tab[3] = '{3'b001, 32'h0000_0200, 32'h9999_1234, 32'h0000_0200, 4'b0011, 32'h1234_1234, 4'd0};
    st_tab[4] = '{3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 4'd2};

    in_r = '0;
    dm.req_ready = 1'b0;
    dm.resp_valid = 1'b0;
    dm.resp_rdata = '0;
    repeat (2) tick();
    chk("reset.out_zero", 32'(out_r != '0), 32'd0);
    chk("reset.req_valid", 32'(dm.req_valid), 32'd0);
    chk("reset.req_we", 32'(dm.req_we), 32'd0);
    chk("reset.req_be", 32'(dm.req_be), 32'd0);
    chk("reset.misalign", 32'(mis), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      in_r = '0;
      in_r.valid = 1'b1;
      in_r.pc = alu_tab[i].pc;
      in_r.dst_reg = 5'd3;
      in_r.dst_reg_data = alu_tab[i].data;
      in_r.reg_data_ready = 1'b1;
      #1;
      chk($sformatf("alu%0d.stall", i), 32'(stall), 32'd0);
      tick();
      chk($sformatf("alu%0d.valid", i), 32'(out_r.valid), 32'd1);
      chk($sformatf("alu%0d.data", i), out_r.dst_reg_data, alu_tab[i].data);
      chk($sformatf("alu%0d.pc", i), out_r.pc, alu_tab[i].pc);
      chk($sformatf("alu%0d.req", i), 32'(dm.req_valid), 32'd0);
    end
    in_r = '0;
    tick();
    chk("alu.bubble", 32'(out_r.valid), 32'd0);

    for (int i = 0; i < 9; i++)
      mem_op($sformatf("ld%0d", i), 1'b0, ld_tab[i].f3, ld_tab[i].addr, 32'h0,
             int'(ld_tab[i].rdy), int'(ld_tab[i].rsp), 1'b0, ld_tab[i].rdata,
             ld_tab[i].addr & 32'hFFFF_FFFC, 4'h0, 32'h0, ld_tab[i].exp);

    for (int i = 0; i < 5; i++)
      mem_op($sformatf("st%0d", i), 1'b1, st_tab[i].f3, st_tab[i].addr, st_tab[i].data,
             int'(st_tab[i].rdy), 0, 1'b0, 32'h0, st_tab[i].exp_addr,
             st_tab[i].exp_be, st_tab[i].exp_wdata, st_tab[i].addr);

    mem_op("lhu_spur", 1'b0, 3'b101, 32'h0000_0010, 32'h0, 2, 5, 1'b1,
           32'h0000_F00D, 32'h0000_0010, 4'h0, 32'h0, 32'h0000_F00D);

    in_r = mk(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
    tick();
    dm.req_ready = 1'b1;
    tick();
    dm.req_ready = 1'b0;
    chk("rstwait.stall", 32'(stall), 32'd1);
    rst = 1'b0;
    in_r = '0;
    tick();
    rst = 1'b1;
    chk("rstwait.out_zero", 32'(out_r != '0), 32'd0);
    chk("rstwait.req_valid", 32'(dm.req_valid), 32'd0);
    chk("rstwait.req_be", 32'(dm.req_be), 32'd0);
    chk("rstwait.req_we", 32'(dm.req_we), 32'd0);
    chk("rstwait.stall", 32'(stall), 32'd0);
    dm.resp_valid = 1'b1;
    dm.resp_rdata = 32'h1357_9BDF;
    tick();
    dm.resp_valid = 1'b0;
    chk("rstwait.late_resp", 32'(out_r.valid), 32'd0);
    chk("rstwait.late_stall", 32'(stall), 32'd0);
    tick();
    chk("rstwait.quiet", 32'(out_r.valid), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    in_r = mk(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
    #1;
    chk("trap_lw.stall", 32'(stall), 32'd0);
    tick();
    in_r = '0;
    chk("trap_lw.misalign", 32'(mis), 32'd1);
    chk("trap_lw.valid", 32'(out_r.valid), 32'd0);
    chk("trap_lw.req", 32'(dm.req_valid), 32'd0);
    tick();
    chk("trap_lw.pulse", 32'(mis), 32'd0);
    chk("trap_lw.req2", 32'(dm.req_valid), 32'd0);
    in_r = mk(1'b0, 1'b1, 3'b001, 32'h0000_0201, 32'h1234_5678);
    tick();
    in_r = '0;
    chk("trap_sh.misalign", 32'(mis), 32'd1);
    chk("trap_sh.req", 32'(dm.req_valid), 32'd0);
    tick();
    chk("trap_sh.pulse", 32'(mis), 32'd0);
`else
    mem_op("lw_mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 1, 1'b0,
           32'h1122_3344, 32'h0000_0100, 4'h0, 32'h0, 32'h1122_3344);
    mem_op("lh_mis", 1'b0, 3'b001, 32'h0000_0203, 32'h0, 0, 0, 1'b0,
           32'h8765_0000, 32'h0000_0200, 4'h0, 32'h0, 32'hFFFF_8765);
    mem_op("sh_mis", 1'b1, 3'b001, 32'h0000_0201, 32'h5555_BEEF, 0, 0, 1'b0,
           32'h0, 32'h0000_0200, 4'b0011, 32'hBEEF_BEEF, 32'h0000_0201);
    mem_op("sw_mis", 1'b1, 3'b010, 32'h0000_0103, 32'hA5A5_5A5A, 1, 0, 1'b0,
           32'h0, 32'h0000_0100, 4'b1111, 32'hA5A5_5A5A, 32'h0000_0103);
    chk("nomis.misalign", 32'(mis), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
